fft_stage_sched: RTL

Frame-level scheduler for one 512-point FFT butterfly/CBFP stage.
- Accepts frames from the upstream stage through a valid/ready handshake and issues a single-cycle start pulse to the stage datapath.
- Tracks the single in-flight frame, since the CBFP block is not re-entrant, and checks the completion flag against minimum-latency and timeout bounds.
- Presents the result downstream with a valid/ready hold.
- Sits between consecutive stage instances and owns their sequencing.

---
 rtl/fft_stage_sched_if.sv | 31 +++
 rtl/fft_stage_sched.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sched_if.sv
// Handshake bundle between an FFT stage scheduler, its upstream/downstream
// neighbours and the butterfly/CBFP datapath it sequences.
interface fft_stage_sched_if;
    logic in_valid;
    logic in_ready;
    logic stage_start;
    logic stage_done;
    logic capture_en;
    logic out_valid;
    logic out_ready;

    modport master (
        input  in_valid,
        output in_ready,
        output stage_start,
        input  stage_done,
        output capture_en,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output in_valid,
        input  in_ready,
        input  stage_start,
        output stage_done,
        input  capture_en,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fft_stage_sched.sv
// Frame scheduler for one 512-point FFT butterfly/CBFP stage.
// Define FFT_SCHED_PERF_EN to add the last_lat / stall_cnt performance outputs.
module fft_stage_sched #(
    parameter int PIPE_LAT = 20,
    parameter int TIMEOUT  = 1023,
    parameter int LAT_W    = 10,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    fft_stage_sched_if.master bus,
    input  logic             sched_en,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             err_timeout,
    output logic             err_spurious,
    input  logic             err_clr
`ifdef FFT_SCHED_PERF_EN
    ,
    output logic [LAT_W-1:0] last_lat,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(TIMEOUT);
    localparam logic [LAT_W-1:0] LAT_PIPE = LAT_W'(PIPE_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             ov_q, ov_d;
    logic             busy_q, busy_d;
    logic             eto_q, eto_d;
    logic             esp_q, esp_d;

    logic accept;
    logic legal;
    logic tmo;
    logic spur;

    assign accept = (state_q == S_IDLE) && sched_en && bus.in_valid;
    assign legal  = (state_q == S_WAIT) && bus.stage_done
                    && (lat_q >= LAT_PIPE);
    assign tmo    = (state_q == S_WAIT) && !legal && (lat_q == LAT_MAX);
    // Done outside a legal window is flagged everywhere except ERR.
    assign spur   = bus.stage_done && !legal && (state_q != S_ERR);

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LAUNCH;
                    lat_d   = '0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                lat_d   = LAT_ONE;
            end
            S_WAIT: begin
                if (legal) begin
                    state_d = S_HOLD;
                end else if (tmo) begin
                    state_d = S_ERR;
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A fresh timeout outranks a same-cycle clear so ERR is never silent.
    always_comb begin
        eto_d   = tmo | (eto_q & ~err_clr);
        esp_d   = ~err_clr & (esp_q | spur);
        start_d = (state_d == S_LAUNCH);
        ov_d    = (state_d == S_HOLD);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            eto_q   <= 1'b0;
            esp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            eto_q   <= eto_d;
            esp_q   <= esp_d;
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE) && sched_en;
    assign bus.capture_en  = legal;
    assign bus.stage_start = start_q;
    assign bus.out_valid   = ov_q;
    assign busy            = busy_q;
    assign frame_cnt       = cnt_q;
    assign err_timeout     = eto_q;
    assign err_spurious    = esp_q;

`ifdef FFT_SCHED_PERF_EN
    logic [LAT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        last_d  = legal ? lat_q : last_q;
        stall_d = stall_q;
        if ((state_q == S_HOLD) && !bus.out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q  <= '0;
            stall_q <= '0;
        end else begin
            last_q  <= last_d;
            stall_q <= stall_d;
        end
    end

    assign last_lat  = last_q;
    assign stall_cnt = stall_q;
`endif

endmodule
